// File: rtl/pt_pkg.sv
// rtl/pt_pkg.sv - shared constants and types for the projective transform path
package pt_pkg;

  localparam int SQRT_NBITS = 21;
  localparam int SQRT_MBITS = 11;

  // Requester slots on the shared square-root unit
  localparam int REQ_AD  = 0;
  localparam int REQ_BC  = 1;
  localparam int REQ_ROW = 2;

  typedef enum logic {
    SQRT_IDLE = 1'b0,
    SQRT_RUN  = 1'b1
  } sqrt_state_e;

endpackage

// File: rtl/sqrt_core.sv
// rtl/sqrt_core.sv - bit-serial integer square root, one result bit per clock
module sqrt_core import pt_pkg::*; #(
  parameter int NBITS = SQRT_NBITS,
  parameter int MBITS = (NBITS + 1) / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_operand,
  output logic             o_last,
  output logic             o_done,
  output logic [MBITS-1:0] o_root
);

  localparam int BW = (MBITS > 1) ? $clog2(MBITS) : 1;
  localparam int PW = 2 * MBITS;

  logic [NBITS-1:0] r_operand;
  logic [MBITS-1:0] r_acc;
  logic [MBITS-1:0] r_root;
  logic [BW-1:0]    r_bit;
  logic             r_run;
  logic             r_done;

  logic [MBITS-1:0] w_trial;
  logic [MBITS-1:0] w_acc_next;
  logic [PW-1:0]    w_trial_w;
  logic [PW-1:0]    w_square;

  // Square is formed at full 2*MBITS width so no trial can wrap
  always_comb begin
    w_trial    = r_acc | (MBITS'(1) << r_bit);
    w_trial_w  = PW'(w_trial);
    w_square   = w_trial_w * w_trial_w;
    w_acc_next = (w_square <= PW'(r_operand)) ? w_trial : r_acc;
  end

  assign o_last = r_run && (r_bit == '0);
  assign o_done = r_done;
  assign o_root = r_root;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_operand <= '0;
      r_acc     <= '0;
      r_root    <= '0;
      r_bit     <= '0;
      r_run     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_operand <= i_operand;
        r_acc     <= '0;
        r_bit     <= BW'(MBITS - 1);
        r_run     <= 1'b1;
      end else if (r_run) begin
        r_acc <= w_acc_next;
        r_bit <= r_bit - 1'b1;
        if (o_last) begin
          r_root <= w_acc_next;
          r_done <= 1'b1;
          r_run  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - shares one sqrt_core among NREQ requesters, results tagged one-hot
// SQRT_ARB_RR_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module sqrt_arbiter import pt_pkg::*; #(
  parameter  int NBITS = SQRT_NBITS,
  parameter  int NREQ  = 3,
  localparam int MBITS = (NBITS + 1) / 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [MBITS-1:0]      answer,
  output logic [NREQ-1:0]       answer_valid,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sqrt_state_e      r_state;
  sqrt_state_e      w_state_next;
  logic [NREQ-1:0]  r_grant;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  logic             w_start;
  logic             w_last;
  logic             w_done;
  logic [NBITS-1:0] w_operand;
  logic [MBITS-1:0] w_root;

`ifdef SQRT_ARB_RR_EN
  logic [IW-1:0] r_ptr;

  // Search begins at the slot after the previous winner and wraps
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_start) begin
      r_ptr <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IW'(k);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
`endif

  always_comb begin
    w_operand = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IW'(k) == w_win) begin
        w_operand = req_data[k*NBITS +: NBITS];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      SQRT_IDLE: begin
        if (w_found) begin
          w_start      = 1'b1;
          w_state_next = SQRT_RUN;
        end
      end
      SQRT_RUN: begin
        if (w_last) begin
          w_state_next = SQRT_IDLE;
        end
      end
      default: w_state_next = SQRT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SQRT_IDLE;
      r_grant <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_start ? (NREQ'(1) << w_win) : '0;
      if (w_start) begin
        r_owner <= w_win;
      end
    end
  end

  sqrt_core #(
    .NBITS (NBITS),
    .MBITS (MBITS)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_operand (w_operand),
    .o_last    (w_last),
    .o_done    (w_done),
    .o_root    (w_root)
  );

  assign grant        = r_grant;
  assign busy         = (r_state == SQRT_RUN);
  assign answer       = w_root;
  assign answer_valid = w_done ? (NREQ'(1) << r_owner) : '0;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - randomized self-checking bench for sqrt_arbiter against a transaction model
module tb_sqrt_arbiter;

  localparam int NBITS = 21;
  localparam int NREQ  = 3;
  localparam int MBITS = 11;
  localparam int QD    = 1024;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] req_data;
  logic [NREQ-1:0]       grant;
  logic [MBITS-1:0]      answer;
  logic [NREQ-1:0]       answer_valid;
  logic                  busy;

  sqrt_arbiter #(.NBITS(NBITS), .NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .answer       (answer),
    .answer_valid (answer_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Requester operand queues
  logic [NBITS-1:0] q_mem [NREQ][QD];
  int q_hd [NREQ];
  int q_tl [NREQ];
  bit gaps = 1'b0;

  // Transaction model of the shared unit
  logic [NREQ-1:0]       drv_req;
  logic [NREQ*NBITS-1:0] drv_data;
  bit                    m_pending;
  int                    m_age;
  int                    m_owner;
  longint                m_data;
  longint                m_answer;
  int                    m_ptr;

  int g_who [QD];
  int g_cyc [QD];
  int g_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit q_empty(input int i);
    return q_hd[i] == q_tl[i];
  endfunction

  task automatic push(input int i, input logic [NBITS-1:0] v);
    q_mem[i][q_tl[i] % QD] = v;
    q_tl[i]++;
  endtask

  task automatic step(input bit nxt_reset);
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] exp_av;
    bit              was_pending;
    int              w;
    @(posedge clk);
    #1;
    cyc++;
    exp_g  = '0;
    exp_av = '0;
    if (reset) begin
      m_pending = 1'b0;
      m_ptr     = 0;
      m_answer  = 0;
    end else begin
      was_pending = m_pending;
      if (m_pending) begin
        m_age++;
        if (m_age == MBITS) begin
          exp_av    = NREQ'(1) << m_owner;
          m_answer  = isqrt(m_data);
          m_pending = 1'b0;
        end
      end
      if (!was_pending) begin
        w = pick(drv_req, m_ptr);
        if (w >= 0) begin
          exp_g     = NREQ'(1) << w;
          m_pending = 1'b1;
          m_age     = 0;
          m_owner   = w;
          m_data    = longint'(drv_data[w*NBITS +: NBITS]);
`ifdef SQRT_ARB_RR_EN
          m_ptr     = (w + 1) % NREQ;
`endif
          q_hd[w]++;
          g_who[g_cnt % QD] = w;
          g_cyc[g_cnt % QD] = cyc;
          g_cnt++;
        end
      end
    end
    check_eq("grant", 32'(grant), 32'(exp_g));
    check_eq("answer_valid", 32'(answer_valid), 32'(exp_av));
    check_eq("busy", 32'(busy), 32'(m_pending));
    check_eq("answer", 32'(answer), 32'(m_answer));
    reset = nxt_reset;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = !q_empty(i) && (!gaps || ($urandom % 4 != 0));
      req_data[i*NBITS +: NBITS] = !q_empty(i) ? q_mem[i][q_hd[i] % QD] : NBITS'($urandom);
    end
    drv_req  = req;
    drv_data = req_data;
  endtask

  task automatic do_reset();
    step(1'b1);
    step(1'b0);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    bit work;
    work = 1'b1;
    while (work && n < budget) begin
      step(1'b0);
      n++;
      work = m_pending;
      for (int i = 0; i < NREQ; i++) if (!q_empty(i)) work = 1'b1;
    end
    check_eq("drain_timeout", 32'(work), 32'd0);
    step(1'b0);
  endtask

  task automatic single_op(input int i, input logic [NBITS-1:0] v, input int exp_ans, input string tag);
    int base;
    base = g_cnt;
    push(i, v);
    run_until_idle(100);
    check_eq({tag, "_owner"}, 32'(g_who[base % QD]), 32'(i));
    check_eq({tag, "_ans"}, 32'(answer), 32'(exp_ans));
  endtask

  initial begin
    int base;
    int pushed;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    drv_req  = '0;
    drv_data = '0;
    m_pending = 1'b0;
    m_age = 0; m_owner = 0; m_data = 0; m_answer = 0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin
      q_hd[i] = 0;
      q_tl[i] = 0;
    end
    step(1'b1);
    step(1'b0);

    single_op(0, 21'd250000, 500, "single");
    single_op(1, 21'd0, 0, "zero");
    single_op(2, 21'd2097151, 1448, "max");
    single_op(0, 21'd1, 1, "one");

    do_reset();
    base = g_cnt;
    push(0, 21'd400);
    push(1, 21'd900);
    push(2, 21'd1600);
    run_until_idle(200);
    for (int k = 0; k < 3; k++) begin
      check_eq("simul_order", 32'(g_who[(base + k) % QD]), 32'(k));
    end
    check_eq("simul_gap01", 32'(g_cyc[(base + 1) % QD] - g_cyc[base % QD]), 32'(MBITS + 1));
    check_eq("simul_gap12", 32'(g_cyc[(base + 2) % QD] - g_cyc[(base + 1) % QD]), 32'(MBITS + 1));
    check_eq("simul_last", 32'(answer), 32'd40);

    base = g_cnt;
    for (int k = 0; k < 10; k++) begin
      push(0, NBITS'($urandom));
      push(2, NBITS'($urandom));
    end
    run_until_idle(1000);
    for (int k = 0; k < 4; k++) begin
`ifdef SQRT_ARB_RR_EN
      check_eq("starve_alt", 32'(g_who[(base + k) % QD]), 32'((k % 2) * 2));
`else
      check_eq("starve_fixed", 32'(g_who[(base + k) % QD]), 32'd0);
`endif
    end

    base = g_cnt;
    push(0, 21'd10000);
    for (int k = 0; k < 6; k++) step(k == 4);
    step(1'b0);
    check_eq("abort_grant", 32'(g_who[base % QD]), 32'd0);
    check_eq("abort_cnt", 32'(g_cnt - base), 32'd1);
    single_op(0, 21'd10000, 100, "rereq");

    gaps   = 1'b1;
    pushed = 0;
    for (int n = 0; n < 3000 && pushed < 200; n++) begin
      if ($urandom % 5 == 0) begin
        case ($urandom % 8)
          0:       push($urandom % NREQ, '0);
          1:       push($urandom % NREQ, '1);
          2:       push($urandom % NREQ, 21'd1);
          default: push($urandom % NREQ, NBITS'($urandom));
        endcase
        pushed++;
      end
      step(1'b0);
    end
    run_until_idle(5000);
    gaps = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
